// File: rtl/mod_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// mod_addsub_ctrl
//
// Initiator-side sequencer for the shared multi-precision adder. Computes
// (a+b) mod m or (a-b) mod m as two adder transactions followed by a
// sign-based select:
//   add: s = a + b,  t = s - m,  result = t<0 ? s : t
//   sub: s = a - b,  t = s + m,  result = s<0 ? t : s
// The second transaction is always issued, so timing is data independent:
// with adder latency L, start to done spans 2L+4 cycles, counting both the
// start cycle and the done cycle.
//
// Optional build macro: MODADD_WATCHDOG_EN
//   Defined   : a 16-bit watchdog aborts a WAIT state after TIMEOUT_CYCLES
//               cycles without add_done, completing with result=0, err=1.
//   Undefined : WAIT states wait indefinitely, err is tied 0.
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   start, op_sub        request (sampled in IDLE only), 0=add / 1=sub
//   in_a, in_b, in_m     operands (a<m, b<m) and modulus (m>0), OPW bits
//   result, done         modular result (held), one-cycle completion pulse
//   busy, err            operation in flight, watchdog flag
//   add_start            adder start pulse
//   add_subtract         adder mode (1 = in_a - in_b)
//   add_shift            adder shift request, always 0
//   add_in_a, add_in_b   514-bit adder operands
//   add_result           515-bit adder result, valid while add_done=1
//   add_done             adder completion
// ---------------------------------------------------------------------------
module mod_addsub_ctrl #(
  parameter int OPW            = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_sub,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic [OPW-1:0]   in_m,
  output logic [OPW-1:0]   result,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic             add_start,
  output logic             add_subtract,
  output logic             add_shift,
  output logic [513:0]     add_in_a,
  output logic [513:0]     add_in_b,
  input  logic [514:0]     add_result,
  input  logic             add_done
);

  localparam int AW  = 514;
  localparam int PAD = AW - OPW;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE1 = 3'd1;
  localparam logic [2:0] ST_WAIT1  = 3'd2;
  localparam logic [2:0] ST_ISSUE2 = 3'd3;
  localparam logic [2:0] ST_WAIT2  = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  // Operands are zero-extended by at least two bits so the adder's sign bit
  // is meaningful, and the watchdog limit must fit its 16-bit counter.
  if (OPW < 1 || OPW > 512) begin : g_bad_opw
    $error("mod_addsub_ctrl: OPW must be in 1..512");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mod_addsub_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [2:0]     state_q, state_d;
  logic           op_q, op_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] m_q, m_d;
  logic [514:0]   s_q, s_d;
  logic [OPW-1:0] result_q, result_d;

`ifdef MODADD_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
`endif

  // Next-state and datapath capture. The second adder result t is never
  // stored: the final select is made on the WAIT2 exit edge straight from
  // add_result, so result is already valid in the FIN (done) cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    result_d = result_q;
`ifdef MODADD_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_sub;
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          state_d = ST_ISSUE1;
`ifdef MODADD_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE1: begin
        state_d = ST_WAIT1;
`ifdef MODADD_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_WAIT1: begin
        if (add_done) begin
          s_d     = add_result;
          state_d = ST_ISSUE2;
        end
`ifdef MODADD_WATCHDOG_EN
        else if (wd_cnt_q == WD_LIMIT) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_FIN;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      ST_ISSUE2: begin
        state_d = ST_WAIT2;
`ifdef MODADD_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_WAIT2: begin
        if (add_done) begin
          // add: t negative means s < m, keep s.
          // sub: s negative means a < b, take the corrected t.
          if (!op_q) begin
            result_d = add_result[514] ? s_q[OPW-1:0] : add_result[OPW-1:0];
          end else begin
            result_d = s_q[514] ? add_result[OPW-1:0] : s_q[OPW-1:0];
          end
          state_d = ST_FIN;
        end
`ifdef MODADD_WATCHDOG_EN
        else if (wd_cnt_q == WD_LIMIT) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_FIN;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
`ifdef MODADD_WATCHDOG_EN
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      result_q <= result_d;
`ifdef MODADD_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Adder-side outputs decode purely from the state register, so they are
  // held stable from each ISSUE cycle through its WAIT exit and fall to 0
  // as soon as reset is asserted.
  always_comb begin
    add_start    = 1'b0;
    add_subtract = 1'b0;
    add_in_a     = '0;
    add_in_b     = '0;
    case (state_q)
      ST_ISSUE1, ST_WAIT1: begin
        add_start    = (state_q == ST_ISSUE1);
        add_subtract = op_q;
        add_in_a     = {{PAD{1'b0}}, a_q};
        add_in_b     = {{PAD{1'b0}}, b_q};
      end
      ST_ISSUE2, ST_WAIT2: begin
        add_start    = (state_q == ST_ISSUE2);
        add_subtract = ~op_q;
        add_in_a     = s_q[513:0];
        add_in_b     = {{PAD{1'b0}}, m_q};
      end
      default: begin
      end
    endcase
  end

  assign add_shift = 1'b0;
  assign result    = result_q;
  assign done      = (state_q == ST_FIN);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
`ifdef MODADD_WATCHDOG_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod_addsub_ctrl
//
// Self-checking bench for mod_addsub_ctrl. A behavioural adder with a
// programmable start-to-done latency answers the DUT's transactions; results
// are compared against a plain-arithmetic modular add/sub reference.
// Build with MODADD_WATCHDOG_EN defined to also exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_mod_addsub_ctrl;

  localparam int OPW     = 512;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic           start = 1'b0;
  logic           op_sub = 1'b0;
  logic [OPW-1:0] in_a = '0;
  logic [OPW-1:0] in_b = '0;
  logic [OPW-1:0] in_m = '0;
  logic [OPW-1:0] result;
  logic           done;
  logic           busy;
  logic           err;
  logic           add_start;
  logic           add_subtract;
  logic           add_shift;
  logic [513:0]   add_in_a;
  logic [513:0]   add_in_b;
  logic [514:0]   add_result = '0;
  logic           add_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mod_addsub_ctrl #(
    .OPW            (OPW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .op_sub       (op_sub),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .err          (err),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_shift    (add_shift),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  // Behavioural adder: done rises lat cycles after the start cycle, is
  // dropped on the edge that samples start, and otherwise stays high.
  int           lat = 2;
  bit           never_done = 1'b0;
  int           mdl_cnt = 0;
  bit           mdl_pend = 1'b0;
  logic [514:0] mdl_pres = '0;

  always @(posedge clk) begin
    if (add_start) begin
      add_done <= 1'b0;
      mdl_pend <= !never_done;
      mdl_cnt  <= lat - 1;
      mdl_pres <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                               : ({1'b0, add_in_a} + {1'b0, add_in_b});
    end else if (mdl_pend) begin
      if (mdl_cnt <= 1) begin
        add_done   <= 1'b1;
        add_result <= mdl_pres;
        mdl_pend   <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // Cumulative pulse counters; tests snapshot and difference them.
  int tot_start = 0;
  int tot_done  = 0;
  always @(posedge clk) begin
    if (add_start) tot_start <= tot_start + 1;
    if (done)      tot_done  <= tot_done + 1;
  end

  // Overall time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global time limit expired");
  end

  function automatic logic [511:0] ref_mod(input logic [511:0] a, input logic [511:0] b,
                                           input logic [511:0] m, input logic sub);
    logic [512:0] x;
    if (!sub) begin
      x = {1'b0, a} + {1'b0, b};
      if (x >= {1'b0, m}) x = x - {1'b0, m};
    end else if (a >= b) begin
      x = {1'b0, a} - {1'b0, b};
    end else begin
      x = {1'b0, m} - {1'b0, b} + {1'b0, a};
    end
    return x[511:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issues one request and waits (bounded) for done. cycles counts the start
  // cycle as 1 and the done cycle inclusive.
  task automatic run_op(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        input logic sub, output logic [511:0] res, output int cycles,
                        output bit timed_out);
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; op_sub = sub; start = 1'b1;
    cycles = 1; timed_out = 1'b1; res = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (done) begin
        res = result;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (result !== '0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    n_checks++; if ({done, busy, err, add_start, add_subtract, add_shift} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000000", {done, busy, err, add_start, add_subtract, add_shift});
    end
    n_checks++; if ({add_in_a, add_in_b} !== '0) begin n_fail++; $display("[TB] FAIL reset_add_in: got nonzero adder operands expected 0"); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if ({done, busy, add_start} !== 3'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %b expected 000", {done, busy, add_start}); end
  endtask

  task automatic test_add();
    logic [511:0] res; int cyc; bit to; int s0, d0;
    lat = 2;
    s0 = tot_start; d0 = tot_done;
    run_op(512'h14, 512'h0A, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL add_corr_timeout: got timeout expected done"); end
    n_checks++; if (res !== 512'h07) begin n_fail++; $display("[TB] FAIL add_corr_result: got %h expected 07", res); end
    n_checks++; if (tot_start - s0 !== 2) begin n_fail++; $display("[TB] FAIL add_corr_starts: got %0d expected 2", tot_start - s0); end
    n_checks++; if (tot_done - d0 !== 1) begin n_fail++; $display("[TB] FAIL add_corr_dones: got %0d expected 1", tot_done - d0); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL add_corr_err: got %b expected 0", err); end
    n_checks++; if (cyc !== 2*lat + 4) begin n_fail++; $display("[TB] FAIL add_corr_latency: got %0d expected %0d", cyc, 2*lat + 4); end
    lat = 4;
    s0 = tot_start;
    run_op(512'h05, 512'h06, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (res !== 512'h0B) begin n_fail++; $display("[TB] FAIL add_nocorr_result: got %h expected 0b", res); end
    n_checks++; if (tot_start - s0 !== 2) begin n_fail++; $display("[TB] FAIL add_nocorr_starts: got %0d expected 2", tot_start - s0); end
    n_checks++; if (cyc !== 2*lat + 4) begin n_fail++; $display("[TB] FAIL add_nocorr_latency: got %0d expected %0d", cyc, 2*lat + 4); end
    run_op(512'h0C, 512'h0B, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (res !== 512'h0) begin n_fail++; $display("[TB] FAIL add_eq_m_result: got %h expected 0", res); end
  endtask

  task automatic test_sub();
    logic [511:0] res; int cyc; bit to;
    lat = 3;
    run_op(512'h05, 512'h09, 512'h17, 1'b1, res, cyc, to);
    n_checks++; if (res !== 512'h13) begin n_fail++; $display("[TB] FAIL sub_neg_result: got %h expected 13", res); end
    n_checks++; if (cyc !== 2*lat + 4) begin n_fail++; $display("[TB] FAIL sub_neg_latency: got %0d expected %0d", cyc, 2*lat + 4); end
    run_op(512'h09, 512'h05, 512'h17, 1'b1, res, cyc, to);
    n_checks++; if (res !== 512'h04) begin n_fail++; $display("[TB] FAIL sub_pos_result: got %h expected 04", res); end
    run_op(512'h11, 512'h11, 512'h17, 1'b1, res, cyc, to);
    n_checks++; if (res !== 512'h0) begin n_fail++; $display("[TB] FAIL sub_eq_result: got %h expected 0", res); end
  endtask

  task automatic test_large();
    logic [511:0] m, res, exp_res; int cyc; bit to;
    m = '0; m[511] = 1'b1; m = m + 512'h1D;
    exp_res = m - 512'd2;
    lat = 3;
    run_op(m - 512'd1, m - 512'd1, m, 1'b0, res, cyc, to);
    n_checks++; if (res !== exp_res) begin n_fail++; $display("[TB] FAIL large_result: got %h expected %h", res, exp_res); end
    n_checks++; if (cyc !== 2*lat + 4) begin n_fail++; $display("[TB] FAIL large_latency: got %0d expected %0d", cyc, 2*lat + 4); end
  endtask

  // A start presented in the done cycle must be ignored.
  task automatic test_back_to_back();
    logic [511:0] res; int cyc; bit to; bit seen; int s1;
    lat = 2; seen = 1'b0;
    @(negedge clk);
    in_a = 512'h14; in_b = 512'h0A; in_m = 512'h17; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
    n_checks++; if (add_shift !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_shift: got %b expected 0", add_shift); end
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done_wait: got no done expected done"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_at_done: got %b expected 0", busy); end
    n_checks++; if (result !== 512'h07) begin n_fail++; $display("[TB] FAIL b2b_result: got %h expected 07", result); end
    in_a = 512'h01; in_b = 512'h01; start = 1'b1;
    s1 = tot_start;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ignored_busy: got %b expected 0", busy); end
    @(negedge clk); @(negedge clk);
    n_checks++; if (tot_start - s1 !== 0) begin n_fail++; $display("[TB] FAIL b2b_ignored_starts: got %0d expected 0", tot_start - s1); end
    run_op(512'h01, 512'h01, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (res !== 512'h02) begin n_fail++; $display("[TB] FAIL b2b_reissue_result: got %h expected 02", res); end
  endtask

  task automatic test_random();
    logic [511:0] m, a, b, res, exp_res; logic sub; int w, cyc, s0, d0, kind; bit to;
    for (int k = 0; k < 24; k++) begin
      lat = $urandom_range(2, 5);
      w = $urandom_range(2, 512);
      m = rand512() >> (512 - w);
      if (m == '0) m = 512'd1;
      a = rand512() % m;
      kind = k % 3;
      if (kind == 0) b = rand512() % m;
      else if (kind == 1) b = (a == '0) ? '0 : m - a;
      else b = a;
      sub = 1'($urandom_range(0, 1));
      exp_res = ref_mod(a, b, m, sub);
      s0 = tot_start; d0 = tot_done;
      run_op(a, b, m, sub, res, cyc, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_timeout[%0d]: got timeout expected done", k); end
      n_checks++; if (res !== exp_res) begin n_fail++; $display("[TB] FAIL rand_result[%0d]: got %h expected %h", k, res, exp_res); end
      n_checks++; if (cyc !== 2*lat + 4) begin n_fail++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", k, cyc, 2*lat + 4); end
      n_checks++; if (tot_start - s0 !== 2 || tot_done - d0 !== 1) begin
        n_fail++; $display("[TB] FAIL rand_pulses[%0d]: got starts=%0d dones=%0d expected 2/1", k, tot_start - s0, tot_done - d0);
      end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_err[%0d]: got %b expected 0", k, err); end
    end
  endtask

  // Reset while waiting on the second transaction: abort with no done.
  task automatic test_reset_mid_op();
    logic [511:0] res; int cyc, s0, d0; bit to, reached;
    lat = 4; reached = 1'b0;
    s0 = tot_start; d0 = tot_done;
    @(negedge clk);
    in_a = 512'h14; in_b = 512'h0A; in_m = 512'h17; op_sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (tot_start - s0 == 2) begin reached = 1'b1; break; end
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_reach_wait2: got no second start expected 2 starts"); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if ({done, busy, err, add_start, add_subtract} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL midrst_flags: got %b expected 00000", {done, busy, err, add_start, add_subtract});
    end
    n_checks++; if (result !== '0 || add_in_a !== '0 || add_in_b !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_data: got result=%h expected 0 with zero adder operands", result);
    end
    repeat (6) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (tot_done - d0 !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d dones expected 0", tot_done - d0); end
    lat = 2;
    run_op(512'h0, 512'h0, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (to !== 1'b0 || res !== '0) begin n_fail++; $display("[TB] FAIL midrst_fresh_result: got %h timeout=%0d expected 0", res, to); end
  endtask

`ifdef MODADD_WATCHDOG_EN
  task automatic test_watchdog();
    logic [511:0] res; int cyc; bit to, seen;
    never_done = 1'b1;
    run_op(512'h05, 512'h06, 512'h17, 1'b0, res, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_timeout_done: got no done expected done"); end
    n_checks++; if (cyc !== TIMEOUT + 3) begin n_fail++; $display("[TB] FAIL wd_latency: got %0d expected %0d", cyc, TIMEOUT + 3); end
    n_checks++; if (res !== '0) begin n_fail++; $display("[TB] FAIL wd_result: got %h expected 0", res); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_err_set: got %b expected 1", err); end
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_err_hold: got %b expected 1", err); end
    never_done = 1'b0; lat = 2; seen = 1'b0;
    in_a = 512'h05; in_b = 512'h06; in_m = 512'h17; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_err_clear: got %b expected 0", err); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1 || result !== 512'h0B) begin n_fail++; $display("[TB] FAIL wd_recover_result: got %h expected 0b", result); end
  endtask
`endif

  initial begin
    $display("[TB] starting mod_addsub_ctrl bench");
    test_reset();
    test_add();
    test_sub();
    test_large();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
`ifdef MODADD_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_addsub_ctrl.md
Name: mod_addsub_ctrl

Overview:
- Sequencer on the initiator side of the multi-precision adder's start/done protocol.
- Computes the modular sum (a+b) mod m or the modular difference (a-b) mod m.
- Each operation is two adder transactions plus a sign-based correction select.
- Sits between the Montgomery datapath controller and one shared adder instance; it drives start/subtract/shift/in_a/in_b and consumes result/done.

Parameters:
- OPW, 512: operand/modulus width. Operands are zero-extended to the adder's 514-bit inputs.
- TIMEOUT_CYCLES, 4096: watchdog limit per adder transaction. Used only with the optional feature.

Ports:
- clk, input, 1: system clock, rising edge.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: operation request. Sampled in IDLE only.
- op_sub, input, 1: 0 = (a+b) mod m, 1 = (a-b) mod m. Captured with start.
- in_a, input, OPW: operand a. Required a < m. Captured with start.
- in_b, input, OPW: operand b. Required b < m. Captured with start.
- in_m, input, OPW: modulus m. Required m > 0. Captured with start.
- result, output, OPW: modular result. Held until the next completion.
- done, output, 1: one-cycle completion pulse.
- busy, output, 1: high from the cycle after start is accepted until done.
- err, output, 1: watchdog flag. Tied 0 without the optional feature.
- add_start, output, 1: adder start pulse.
- add_subtract, output, 1: adder mode.
- add_shift, output, 1: adder shift request. Always 0.
- add_in_a, output, 514: adder operand a.
- add_in_b, output, 514: adder operand b.
- add_result, input, 515: adder result. Valid while add_done=1.
- add_done, input, 1: adder completion.

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0 (result, done, busy, err, add_start, add_subtract, add_in_a, add_in_b). Operand registers cleared.
- Reset mid-operation: abort immediately and return to IDLE. No done pulse. The adder is left to finish; its result is ignored.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN.
- IDLE: on start=1, capture a, b, m, op_sub; go to ISSUE1. start while not IDLE is ignored.
- ISSUE1: add_start=1 for exactly this cycle.
  - add: add_in_a=a, add_in_b=b, add_subtract=0.
  - sub: add_in_a=a, add_in_b=b, add_subtract=1.
  - Next state WAIT1.
- WAIT1: add_done is sampled only in WAIT states. The adder must drop done on the edge that samples start. On add_done=1, latch s=add_result; go to ISSUE2.
- ISSUE2:
  - add: issue s[513:0] - m (add_subtract=1).
  - sub: issue s[513:0] + m (add_subtract=0).
  - add_start=1 for one cycle; next state WAIT2.
- WAIT2: on add_done=1, latch t=add_result; go to FIN.
- FIN selection:
  - add: result = t[514] ? s[OPW-1:0] : t[OPW-1:0]. t[514]=1 means s<m.
  - sub: result = s[514] ? t[OPW-1:0] : s[OPW-1:0]. s[514]=1 means a<b.
  - done=1 for this cycle only; busy drops; next state IDLE.
- add_subtract, add_in_a, add_in_b: held stable from each ISSUE cycle through the matching WAIT exit.
- Second transaction: always issued, even when no correction is needed (fixed schedule, data-independent timing).
- Latency: with adder latency L cycles (start to done), start to done = 2L+4 cycles.
- a+b = m exactly: t = 0, result 0.
- a = b in sub mode: s = 0, result 0.
- A start may be presented in the same cycle done is high. It is ignored, because the block is not in IDLE; the requester must reissue it on the next cycle.

Optional Feature:
- Macro: MODADD_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on each ISSUE cycle and increments in WAIT1/WAIT2.
  - On reaching TIMEOUT_CYCLES with add_done=0: go to FIN with result=0, err=1, done pulse.
  - err holds until the next accepted start.
- Undefined: no counter; WAIT states wait indefinitely; err tied 0.

Test Plan:
- m=0x17, a=0x14, b=0x0A, op_sub=0 -> result=0x07, done once, err=0, exactly two add_start pulses.
- m=0x17, a=0x05, b=0x06, op_sub=0 -> result=0x0B (no correction; second transaction still issued).
- m=0x17, a=0x05, b=0x09, op_sub=1 -> result=0x13; m=0x17, a=0x09, b=0x05, op_sub=1 -> result=0x04.
- Large case: 512-bit m=2^511+0x1D, a=m-1, b=m-1, op_sub=0 -> result=m-2; start-to-done = 2L+4 cycles.
- Assert resetn=0 during WAIT2 -> no done pulse, all outputs 0 asynchronously; a fresh start after release (m=0x17, a=0, b=0) -> result=0.
- MODADD_WATCHDOG_EN defined, TIMEOUT_CYCLES=16, adder model never asserts done -> done and err after 16 WAIT1 cycles, result=0; err clears on next start.
